soc_addr_router: RTL and testbench

SOC_ADDR_ROUTER -- requirements
Module: soc_addr_router

---
 rtl/soc_addr_router.sv | 199 +++++++++++++++++++
 tb/tb_soc_addr_router.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_addr_router.sv
// soc_addr_router: single-outstanding address router from one upstream master
// to ten memory-mapped slaves. It decodes the address against a fixed map,
// forwards the request to the selected slave, waits for the response with a
// bounded timeout, and returns the response upstream. Unmapped addresses and
// timeouts both return err=1 with rdata=0.
//
// Handshake rule for every valid/ready pair on this block: a transfer happens
// on a rising clk edge where valid and ready are both 1. Once a valid is
// raised, it and its payload stay unchanged until that transfer.
//
// Slave index map (bit position in slv_req_valid_o):
//   0 DRAM, 1 GPIO, 2 Ethernet, 3 SPI, 4 Timer,
//   5 UART, 6 PLIC, 7 CLINT, 8 ROM, 9 Debug
module soc_addr_router #(
    parameter int IdWidth       = 5,
    parameter int TimeoutCycles = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [63:0]         req_addr_i,
    input  logic                req_we_i,
    input  logic [63:0]         req_wdata_i,
    input  logic [IdWidth-1:0]  req_id_i,
    output logic [9:0]          slv_req_valid_o,
    input  logic [9:0]          slv_req_ready_i,
    output logic [63:0]         slv_addr_o,
    output logic                slv_we_o,
    output logic [63:0]         slv_wdata_o,
    input  logic [9:0]          slv_rsp_valid_i,
    input  logic [9:0][63:0]    slv_rsp_rdata_i,
    input  logic [9:0]          slv_rsp_err_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [63:0]         rsp_rdata_o,
    output logic                rsp_err_o,
    output logic [IdWidth-1:0]  rsp_id_o,
    output logic [2:0]          dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FWD  = 3'd1,
        ST_WAIT = 3'd2,
        ST_ERR  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // Last WAIT-cycle count before the transaction is declared timed out.
    localparam logic [15:0] CntLast = 16'(TimeoutCycles - 1);

    state_t               state_q;
    logic [15:0]          cnt_q;
    logic [3:0]           idx_q;
    logic [IdWidth-1:0]   id_q;

    logic                 dec_hit;
    logic [3:0]           dec_idx;
    logic [64:0]          addr_ext;
    logic [64:0]          win_lo;
    logic [64:0]          win_hi;

    function automatic logic [63:0] slave_base(input int i);
        case (i)
            0:       slave_base = 64'h0000_0000;  // DRAM
            1:       slave_base = 64'h4000_0000;  // GPIO
            2:       slave_base = 64'h3000_0000;  // Ethernet
            3:       slave_base = 64'h2000_0000;  // SPI
            4:       slave_base = 64'h1800_0000;  // Timer
            5:       slave_base = 64'h1000_0000;  // UART
            6:       slave_base = 64'h0C00_0000;  // PLIC
            7:       slave_base = 64'h0200_0000;  // CLINT
            8:       slave_base = 64'h0001_0000;  // ROM
            9:       slave_base = 64'h8000_0000;  // Debug
            default: slave_base = 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] slave_length(input int i);
        case (i)
            0:       slave_length = 64'h4000_0000;
            1:       slave_length = 64'h0000_1000;
            2:       slave_length = 64'h0001_0000;
            3:       slave_length = 64'h0080_0000;
            4:       slave_length = 64'h0000_1000;
            5:       slave_length = 64'h0000_1000;
            6:       slave_length = 64'h03FF_FFFF;
            7:       slave_length = 64'h000C_0000;
            8:       slave_length = 64'h0001_0000;
            9:       slave_length = 64'h0000_1000;
            default: slave_length = 64'h0;
        endcase
    endfunction

    // Address decode: 65-bit window compare so base+length never wraps; the
    // ascending scan lets a higher-index slave override DRAM on overlap.
    always_comb begin
        dec_hit  = 1'b0;
        dec_idx  = 4'd0;
        addr_ext = {1'b0, req_addr_i};
        win_lo   = '0;
        win_hi   = '0;
        for (int i = 0; i < 10; i++) begin
            win_lo = {1'b0, slave_base(i)};
            win_hi = win_lo + {1'b0, slave_length(i)};
            if (addr_ext >= win_lo && addr_ext < win_hi) begin
                dec_hit = 1'b1;
                dec_idx = 4'(i);
            end
        end
    end

    assign dbg_state_o = state_q;

    // Transaction FSM with all outward signals registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            idx_q           <= '0;
            id_q            <= '0;
            req_ready_o     <= 1'b0;
            slv_req_valid_o <= '0;
            slv_addr_o      <= '0;
            slv_we_o        <= 1'b0;
            slv_wdata_o     <= '0;
            rsp_valid_o     <= 1'b0;
            rsp_rdata_o     <= '0;
            rsp_err_o       <= 1'b0;
            rsp_id_o        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        slv_addr_o  <= req_addr_i;
                        slv_we_o    <= req_we_i;
                        slv_wdata_o <= req_wdata_i;
                        id_q        <= req_id_i;
                        idx_q       <= dec_idx;
                        if (dec_hit) begin
                            slv_req_valid_o <= 10'b1 << dec_idx;
                            state_q         <= ST_FWD;
                        end else begin
                            state_q <= ST_ERR;
                        end
                    end
                end
                ST_FWD: begin
                    // No timeout here: a slave that never accepts stalls the router.
                    if (slv_req_ready_i[idx_q]) begin
                        slv_req_valid_o <= '0;
                        cnt_q           <= '0;
                        state_q         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response in the timeout cycle takes precedence.
                    if (slv_rsp_valid_i[idx_q]) begin
                        rsp_rdata_o <= slv_rsp_rdata_i[idx_q];
                        rsp_err_o   <= slv_rsp_err_i[idx_q];
                        rsp_id_o    <= id_q;
                        rsp_valid_o <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (cnt_q == CntLast) begin
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_id_o    <= id_q;
                        rsp_valid_o <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_ERR: begin
                    rsp_rdata_o <= '0;
                    rsp_err_o   <= 1'b1;
                    rsp_id_o    <= id_q;
                    rsp_valid_o <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    // Slave responses are ignored here, so late ones are dropped.
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_addr_router.sv
// tb_soc_addr_router: directed and randomized transactions checked against an
// address-map model and a response scoreboard.
module tb_soc_addr_router;

    localparam int IdW = 5;
    localparam int To  = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [63:0]       req_addr_i;
    logic              req_we_i;
    logic [63:0]       req_wdata_i;
    logic [IdW-1:0]    req_id_i;
    logic [9:0]        slv_req_valid_o;
    logic [9:0]        slv_req_ready_i;
    logic [63:0]       slv_addr_o;
    logic              slv_we_o;
    logic [63:0]       slv_wdata_o;
    logic [9:0]        slv_rsp_valid_i;
    logic [9:0][63:0]  slv_rsp_rdata_i;
    logic [9:0]        slv_rsp_err_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [63:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic [IdW-1:0]    rsp_id_o;
    logic [2:0]        dbg_state_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] last_sel;
    logic [69:0] exp_q[$];

    // Address map in specification order: index, base, length.
    logic [63:0] map_base [10] = '{64'h0, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000,
                                   64'h1800_0000, 64'h1000_0000, 64'h0C00_0000,
                                   64'h0200_0000, 64'h1_0000, 64'h8000_0000};
    logic [63:0] map_len  [10] = '{64'h4000_0000, 64'h1000, 64'h1_0000, 64'h80_0000,
                                   64'h1000, 64'h1000, 64'h3FF_FFFF, 64'hC_0000,
                                   64'h1_0000, 64'h1000};

    soc_addr_router #(.IdWidth(IdW), .TimeoutCycles(To)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_we_i(req_we_i),
        .req_wdata_i(req_wdata_i), .req_id_i(req_id_i),
        .slv_req_valid_o(slv_req_valid_o), .slv_req_ready_i(slv_req_ready_i),
        .slv_addr_o(slv_addr_o), .slv_we_o(slv_we_o), .slv_wdata_o(slv_wdata_o),
        .slv_rsp_valid_i(slv_rsp_valid_i), .slv_rsp_rdata_i(slv_rsp_rdata_i),
        .slv_rsp_err_i(slv_rsp_err_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_id_o(rsp_id_o),
        .dbg_state_o(dbg_state_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] want);
        n_checks++;
        if (got !== want)
            $display("FAIL %s: got %h expected %h", tag, got, want);
        else
            n_pass++;
    endtask

    // Reference decode: highest index whose window contains addr wins.
    task automatic ref_decode(input logic [63:0] addr, output logic hit, output int idx);
        logic [64:0] a;
        logic [64:0] lo;
        hit = 1'b0;
        idx = 0;
        a   = {1'b0, addr};
        for (int k = 9; k >= 0; k--) begin
            lo = {1'b0, map_base[k]};
            if (!hit && a >= lo && a - lo < {1'b0, map_len[k]}) begin
                hit = 1'b1;
                idx = k;
            end
        end
    endtask

    task automatic fill_slave_noise();
        for (int k = 0; k < 10; k++) slv_rsp_rdata_i[k] = {$urandom, $urandom};
        slv_rsp_err_i = 10'($urandom);
    endtask

    // Drives one full transaction; rsp_dly >= To means the slave never answers in time.
    task automatic run_txn(input logic [63:0] addr, input logic we, input logic [63:0] wdata,
                           input logic [IdW-1:0] id, input int rdy_dly, input int rsp_dly,
                           input logic [63:0] rdata, input logic err, input int stall);
        logic hit;
        int idx;
        logic [9:0] onehot;
        logic [69:0] want;
        ref_decode(addr, hit, idx);
        onehot = '0;
        if (hit) onehot[idx] = 1'b1;
        if (!hit || rsp_dly >= To) exp_q.push_back({1'b1, 64'h0, id});
        else exp_q.push_back({err, rdata, id});

        @(negedge clk_i);
        check("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we; req_wdata_i = wdata; req_id_i = id;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0; req_addr_i = {$urandom, $urandom}; req_wdata_i = {$urandom, $urandom};
        req_id_i = IdW'($urandom); req_we_i = 1'($urandom);
        last_sel = slv_req_valid_o;
        check("req_ready_busy", req_ready_o, 0);
        check("rsp_early_fwd", rsp_valid_o, 0);
        check("slv_sel", slv_req_valid_o, onehot);
        if (hit) begin
            check("slv_req", {slv_we_o, slv_addr_o, slv_wdata_o}, {we, addr, wdata});
            for (int c = 0; c < rdy_dly; c++) begin
                slv_req_ready_i = 10'($urandom);
                slv_req_ready_i[idx] = 1'b0;
                @(posedge clk_i);
                @(negedge clk_i);
                check("slv_hold", slv_req_valid_o, onehot);
            end
            slv_req_ready_i = 10'($urandom) | onehot;
            @(posedge clk_i);
            @(negedge clk_i);
            slv_req_ready_i = '0;
            check("slv_drop", slv_req_valid_o, 0);
            for (int w = 0; w < To; w++) begin
                check("rsp_early_wait", rsp_valid_o, 0);
                fill_slave_noise();
                slv_rsp_valid_i = 10'($urandom);
                slv_rsp_valid_i[idx] = (w == rsp_dly);
                slv_rsp_rdata_i[idx] = rdata;
                slv_rsp_err_i[idx]   = err;
                @(posedge clk_i);
                @(negedge clk_i);
                if (w == rsp_dly) break;
            end
            // A timed-out slave answers late, during RESP; it must be dropped.
            slv_rsp_valid_i = (rsp_dly >= To) ? onehot : 10'h0;
            slv_rsp_rdata_i[idx] = {$urandom, $urandom} | 64'h1;
            slv_rsp_err_i[idx]   = 1'b0;
        end else begin
            @(posedge clk_i);
            @(negedge clk_i);
        end
        want = exp_q.pop_front();
        for (int s = 0; s <= stall; s++) begin
            check("rsp_valid", rsp_valid_o, 1);
            check("rsp_payload", {rsp_err_o, rsp_rdata_o, rsp_id_o}, want);
            check("req_ready_resp", req_ready_o, 0);
            check("slv_quiet_resp", slv_req_valid_o, 0);
            if (s == stall) rsp_ready_i = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
        end
        rsp_ready_i = 1'b0;
        slv_rsp_valid_i = '0;
        check("rsp_done", rsp_valid_o, 0);
        check("req_ready_back", req_ready_o, 1);
    endtask

    initial begin
        logic [63:0] a;
        int k;
        int mode;
        rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0; req_wdata_i = '0;
        req_id_i = '0; slv_req_ready_i = '0; slv_rsp_valid_i = '0; slv_rsp_rdata_i = '0;
        slv_rsp_err_i = '0; rsp_ready_i = 1'b0; last_sel = '0;

        // Reset values while rst_i is held
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready", req_ready_o, 0);
        check("rst_slv", {slv_req_valid_o, slv_we_o}, 0);
        check("rst_slv_addr", {slv_addr_o, slv_wdata_o}, 0);
        check("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o, rsp_id_o}, 0);
        rst_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("ready_after_rst", req_ready_o, 1);

        // UART read, immediate slave: FWD and WAIT cycles, then response
        run_txn(64'h1000_0008, 1'b0, 64'h0, 5'd3, 0, 0, 64'hAB, 1'b0, 0);
        check("uart_sel", last_sel, 10'h020);
        // Overlap priority
        run_txn(64'h8000_0010, 1'b1, 64'h1234, 5'd1, 1, 1, 64'h55, 1'b0, 0);
        check("debug_sel", last_sel, 10'h200);
        run_txn(64'h0001_0000, 1'b0, 64'h0, 5'd2, 0, 2, 64'h66, 1'b1, 1);
        check("rom_sel", last_sel, 10'h100);
        run_txn(64'h3FFF_FFF8, 1'b0, 64'h0, 5'd4, 0, 0, 64'h77, 1'b0, 0);
        check("dram_sel", last_sel, 10'h001);
        // Unmapped address
        run_txn(64'h5000_0000, 1'b0, 64'h0, 5'd7, 0, 0, 64'h0, 1'b0, 0);
        check("unmapped_sel", last_sel, 10'h000);
        // CLINT never answers: timeout, then normal decode
        run_txn(64'h0200_0000, 1'b0, 64'h0, 5'd9, 0, 99, 64'hDEAD, 1'b0, 0);
        check("clint_sel", last_sel, 10'h080);
        run_txn(64'h1800_0004, 1'b1, 64'hF00D, 5'd10, 0, 0, 64'h99, 1'b0, 0);
        check("timer_after_timeout", last_sel, 10'h010);
        // Response coincides with the timeout cycle
        run_txn(64'h2000_0000, 1'b0, 64'h0, 5'd11, 0, To - 1, 64'hBEEF, 1'b0, 0);
        // Upstream stalls five cycles
        run_txn(64'h3000_0040, 1'b0, 64'h0, 5'd12, 2, 1, 64'hCAFE, 1'b1, 5);
        // Window edges
        run_txn(64'h0FFF_FFFE, 1'b0, 64'h0, 5'd13, 0, 0, 64'h1, 1'b0, 0);
        check("plic_end_sel", last_sel, 10'h040);
        run_txn(64'h4000_0000, 1'b0, 64'h0, 5'd14, 0, 0, 64'h2, 1'b0, 0);
        check("gpio_sel", last_sel, 10'h002);
        run_txn(64'h4000_1000, 1'b0, 64'h0, 5'd15, 0, 0, 64'h3, 1'b0, 0);
        check("gpio_past_end", last_sel, 10'h000);
        run_txn(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 5'd16, 0, 0, 64'h4, 1'b0, 0);
        check("top_addr_sel", last_sel, 10'h000);

        // Reset while in WAIT abandons the transaction
        @(negedge clk_i);
        req_valid_i = 1'b1; req_addr_i = 64'h1000_0000; req_id_i = 5'd9;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        slv_req_ready_i = 10'h020;
        @(posedge clk_i);
        @(negedge clk_i);
        slv_req_ready_i = '0;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("rst_wait_rsp", rsp_valid_o, 0);
        check("rst_wait_slv", slv_req_valid_o, 0);
        check("rst_wait_ready", req_ready_o, 0);
        rst_i = 1'b0;
        slv_rsp_valid_i = 10'h020;
        slv_rsp_rdata_i[5] = 64'h1111;
        @(posedge clk_i);
        @(negedge clk_i);
        slv_rsp_valid_i = '0;
        check("post_rst_rsp", rsp_valid_o, 0);
        check("post_rst_ready", req_ready_o, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        check("post_rst_rsp2", rsp_valid_o, 0);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            k    = $urandom_range(0, 9);
            mode = $urandom_range(0, 4);
            case (mode)
                0, 1:    a = map_base[k] + 64'($urandom_range(0, 32'(map_len[k] - 64'd1)));
                2:       a = map_base[k] + map_len[k] - 64'd1;
                3:       a = map_base[k] + map_len[k];
                default: a = {$urandom, $urandom};
            endcase
            run_txn(a, 1'($urandom), {$urandom, $urandom}, IdW'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 5), {$urandom, $urandom},
                    1'($urandom), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
